// File: rtl/ysyx_25040111_ifu_pkg.sv
// ysyx_25040111_ifu_pkg: FSM state encodings and default reset/NOP constants shared by the IFU files
package ysyx_25040111_ifu_pkg;
    typedef enum logic [2:0] {
        S_BOOT = 3'd0,
        S_REQ  = 3'd1,
        S_WAIT = 3'd2,
        S_OUT  = 3'd3,
        S_NPC  = 3'd4
    } ifu_state_t;
    localparam logic [31:0] RESET_PC_DEF = 32'h8000_0000;
    localparam logic [31:0] NOP_INST_DEF = 32'h0000_0013;
endpackage

// File: rtl/ysyx_25040111_ifu_fsm.sv
// ysyx_25040111_ifu_fsm: IFU sequencing FSM (BOOT->REQ->WAIT->OUT->NPC) emitting per-state enables
//   in : clock, reset, i_req_ready, i_rsp_valid, i_idu_ready, i_npc_valid, i_npc_mis
//   out: o_req (in REQ), o_out (in OUT), o_rsp_take (response latched), o_npc_take (next PC loaded)
module ysyx_25040111_ifu_fsm
    import ysyx_25040111_ifu_pkg::*;
(
    input  logic clock,
    input  logic reset,
    input  logic i_req_ready,
    input  logic i_rsp_valid,
    input  logic i_idu_ready,
    input  logic i_npc_valid,
    input  logic i_npc_mis,
    output logic o_req,
    output logic o_out,
    output logic o_rsp_take,
    output logic o_npc_take
);
    ifu_state_t r_state;
    ifu_state_t w_next;

    always_ff @(posedge clock) begin
        r_state <= reset ? S_BOOT : w_next;
    end

    // A misaligned next PC skips the bus and goes straight to presenting a fault.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_BOOT:  w_next = S_REQ;
            S_REQ:   w_next = i_req_ready ? S_WAIT : S_REQ;
            S_WAIT:  w_next = i_rsp_valid ? S_OUT : S_WAIT;
            S_OUT:   w_next = i_idu_ready ? S_NPC : S_OUT;
            S_NPC:   w_next = !i_npc_valid ? S_NPC : (i_npc_mis ? S_OUT : S_REQ);
            default: w_next = S_BOOT;
        endcase
    end

    assign o_req      = r_state == S_REQ;
    assign o_out      = r_state == S_OUT;
    assign o_rsp_take = (r_state == S_WAIT) && i_rsp_valid;
    assign o_npc_take = (r_state == S_NPC) && i_npc_valid;
endmodule

// File: rtl/ysyx_25040111_ifu.sv
// ysyx_25040111_ifu: instruction fetch unit holding the PC, fetching one word per instruction and handing {pc, inst} to the IDU
//   clock/reset            : single clock, synchronous active-high reset
//   imem_req_*             : fetch request (valid/ready, addr)
//   imem_rsp_*             : fetch response (valid, data, err); always accepted while waiting
//   idu_*                  : registered {pc, inst, fault} with valid/ready handoff
//   npc_valid/npc          : next PC from the WBU
//   YSYX_25040111_IFU_MISALIGN_CHK_EN : when defined, a misaligned npc raises a fault without a bus request
module ysyx_25040111_ifu
    import ysyx_25040111_ifu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF,
    parameter logic [31:0] NOP_INST = NOP_INST_DEF
)
(
    input  logic        clock,
    input  logic        reset,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        imem_rsp_err,
    output logic        idu_valid,
    input  logic        idu_ready,
    output logic [31:0] idu_pc,
    output logic [31:0] idu_inst,
    output logic        idu_fault,
    input  logic        npc_valid,
    input  logic [31:0] npc
);
    logic [31:0] r_pc;
    logic [31:0] r_idu_pc;
    logic [31:0] r_idu_inst;
    logic        r_idu_fault;
    logic        w_req;
    logic        w_out;
    logic        w_rsp_take;
    logic        w_npc_take;
    logic        w_npc_mis;

`ifdef YSYX_25040111_IFU_MISALIGN_CHK_EN
    assign w_npc_mis = |npc[1:0];
`else
    assign w_npc_mis = 1'b0;
`endif

    ysyx_25040111_ifu_fsm u_fsm (
        .clock       (clock),
        .reset       (reset),
        .i_req_ready (imem_req_ready),
        .i_rsp_valid (imem_rsp_valid),
        .i_idu_ready (idu_ready),
        .i_npc_valid (npc_valid),
        .i_npc_mis   (w_npc_mis),
        .o_req       (w_req),
        .o_out       (w_out),
        .o_rsp_take  (w_rsp_take),
        .o_npc_take  (w_npc_take)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_pc        <= RESET_PC;
            r_idu_pc    <= RESET_PC;
            r_idu_inst  <= NOP_INST;
            r_idu_fault <= 1'b0;
        end else begin
            if (w_rsp_take) begin
                r_idu_pc    <= r_pc;
                r_idu_inst  <= imem_rsp_err ? NOP_INST : imem_rsp_data;
                r_idu_fault <= imem_rsp_err;
            end
            if (w_npc_take) begin
                r_pc <= npc;
                if (w_npc_mis) begin
                    r_idu_pc    <= npc;
                    r_idu_inst  <= NOP_INST;
                    r_idu_fault <= 1'b1;
                end
            end
        end
    end

    assign imem_req_valid = w_req;
    assign imem_req_addr  = r_pc;
    assign idu_valid      = w_out;
    assign idu_pc         = r_idu_pc;
    assign idu_inst       = r_idu_inst;
    assign idu_fault      = r_idu_fault;
endmodule

// File: tb/tb_ysyx_25040111_ifu.sv
// tb_ysyx_25040111_ifu: randomized scoreboard bench for the IFU with a transaction-level reference model
module tb_ysyx_25040111_ifu;
`ifdef YSYX_25040111_IFU_MISALIGN_CHK_EN
    localparam bit MIS_EN = 1'b1;
`else
    localparam bit MIS_EN = 1'b0;
`endif
    localparam logic [31:0] RPC = 32'h8000_0000;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        imem_rsp_err = 1'b0;
    logic        idu_valid;
    logic        idu_ready = 1'b0;
    logic [31:0] idu_pc;
    logic [31:0] idu_inst;
    logic        idu_fault;
    logic        npc_valid = 1'b0;
    logic [31:0] npc = '0;

    int n_pass = 0;
    int n_total = 0;
    int cyc = 0;
    int out_cyc = 0;
    logic [64:0] idu_q[$];
    logic [31:0] addr_q[$];
    logic [31:0] cur_pc;
    logic        cur_mis;

    always #5 clock = ~clock;

    ysyx_25040111_ifu dut (
        .clock          (clock),
        .reset          (reset),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .imem_rsp_err   (imem_rsp_err),
        .idu_valid      (idu_valid),
        .idu_ready      (idu_ready),
        .idu_pc         (idu_pc),
        .idu_inst       (idu_inst),
        .idu_fault      (idu_fault),
        .npc_valid      (npc_valid),
        .npc            (npc)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
        cyc++;
    endtask

    task automatic noise();
        imem_rsp_valid = 1'($urandom_range(0, 1));
        imem_rsp_data  = $urandom;
        imem_rsp_err   = 1'($urandom_range(0, 1));
    endtask

    task automatic reset_chk();
        chk("rst_req_valid", 32'(imem_req_valid), 0);
        chk("rst_req_addr", imem_req_addr, RPC);
        chk("rst_idu_valid", 32'(idu_valid), 0);
        chk("rst_idu_pc", idu_pc, RPC);
        chk("rst_idu_inst", idu_inst, NOP);
        chk("rst_idu_fault", 32'(idu_fault), 0);
    endtask

    // One instruction: fetch (unless the previous npc was a trapped misaligned one), present, then supply nxt.
    task automatic txn(input int req_hold, input int rsp_lat, input logic [31:0] data, input logic err,
                       input int out_hold, input logic [31:0] nxt);
        int n;
        logic mis;
        if (!cur_mis) begin
            n = 0;
            while (!imem_req_valid && n < 10) begin tick(); n++; end
            chk("req_seen", 32'(imem_req_valid), 1);
            imem_req_ready = 1'b0;
            repeat (req_hold) begin noise(); tick(); chk("req_held", 32'(imem_req_valid), 1); end
            imem_rsp_valid = 1'b0;
            imem_req_ready = 1'b1;
            tick();
            imem_req_ready = 1'b0;
            chk("req_dropped", 32'(imem_req_valid), 0);
            repeat (rsp_lat) begin tick(); chk("no_early_out", 32'(idu_valid), 0); end
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = data;
            imem_rsp_err   = err;
            idu_q.push_back({cur_pc, err ? NOP : data, err});
            tick();
            imem_rsp_valid = 1'b0;
        end
        out_cyc = cyc;
        chk("out_valid", 32'(idu_valid), 1);
        idu_ready = 1'b0;
        repeat (out_hold) begin noise(); tick(); chk("out_held", 32'(idu_valid), 1); end
        imem_rsp_valid = 1'b0;
        idu_ready = 1'b1;
        tick();
        idu_ready = 1'($urandom_range(0, 1));
        chk("out_dropped", 32'(idu_valid), 0);
        repeat ($urandom_range(0, 2)) begin noise(); tick(); chk("npc_wait", 32'(imem_req_valid | idu_valid), 0); end
        mis = MIS_EN && (nxt[1:0] != 2'b00);
        if (mis) idu_q.push_back({nxt, NOP, 1'b1});
        else addr_q.push_back(nxt);
        imem_rsp_valid = 1'b0;
        npc_valid = 1'b1;
        npc = nxt;
        tick();
        npc_valid = 1'b0;
        npc = $urandom;
        chk("npc_to_req", 32'(imem_req_valid), 32'(!mis));
        chk("npc_to_out", 32'(idu_valid), 32'(mis));
        cur_pc  = nxt;
        cur_mis = mis;
    endtask

    always @(negedge clock) begin
        if (!reset) begin
            if (idu_valid) begin
                if (idu_q.size() == 0) chk("idu_unexpected", 32'(idu_valid), 0);
                else begin
                    chk("idu_pc", idu_pc, idu_q[0][64:33]);
                    chk("idu_inst", idu_inst, idu_q[0][32:1]);
                    chk("idu_fault", 32'(idu_fault), 32'(idu_q[0][0]));
                    if (idu_ready) void'(idu_q.pop_front());
                end
            end
            if (imem_req_valid) begin
                chk("req_during_out", 32'(idu_valid), 0);
                if (addr_q.size() == 0) chk("req_unexpected", 32'(imem_req_valid), 0);
                else begin
                    chk("req_addr", imem_req_addr, addr_q[0]);
                    if (imem_req_ready) void'(addr_q.pop_front());
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        logic [31:0] nx;
        int n;
        repeat (3) tick();
        reset_chk();
        addr_q.push_back(RPC);
        cur_pc  = RPC;
        cur_mis = 1'b0;
        reset = 1'b0;
        cyc = 0;
        chk("boot_no_req", 32'(imem_req_valid), 0);
        txn(0, 0, 32'h0000_0033, 1'b0, 5, 32'h8000_0010);
        chk("first_out_cycle", out_cyc, 3);
        txn(3, 1, $urandom, 1'b1, 0, 32'h8000_0002);
        txn(1, 0, $urandom, 1'b0, 1, 32'h8000_0020);
        for (int i = 0; i < 150; i++) begin
            nx = $urandom;
            if ($urandom_range(0, 3) != 0) nx[1:0] = 2'b00;
            txn($urandom_range(0, 3), $urandom_range(0, 3), $urandom, $urandom_range(0, 3) == 0,
                $urandom_range(0, 4), nx);
        end
        txn(0, 0, $urandom, 1'b0, 0, 32'h8000_0100);
        n = 0;
        while (!imem_req_valid && n < 10) begin tick(); n++; end
        chk("req_before_reset", 32'(imem_req_valid), 1);
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0;
        chk("wait_before_reset", 32'(imem_req_valid), 0);
        reset = 1'b1;
        tick();
        idu_q.delete();
        addr_q.delete();
        addr_q.push_back(RPC);
        cur_pc  = RPC;
        cur_mis = 1'b0;
        reset_chk();
        reset = 1'b0;
        cyc = 0;
        chk("reboot_no_req", 32'(imem_req_valid), 0);
        txn(0, 0, 32'h0000_0033, 1'b0, 0, 32'h8000_0004);
        chk("reboot_out_cycle", out_cyc, 3);
        chk("idu_q_drained", idu_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
